// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand format, special encodings, flag bit
// positions and the unpacked-operand record used by the arithmetic units.
package fpu_pkg;

  // Operand format of the FPU datapath; unit width parameters default to these
  localparam int unsigned FP_EXP_W = 8;
  localparam int unsigned FP_MAN_W = 23;

  localparam logic [FP_EXP_W-1:0]         EXP_MAX   = '1;
  localparam logic [FP_EXP_W-1:0]         BIAS      = {1'b0, {(FP_EXP_W-1){1'b1}}};
  localparam logic [FP_EXP_W+FP_MAN_W:0]  CANON_NAN = {1'b0, EXP_MAX, 1'b1, {(FP_MAN_W-1){1'b0}}};

  // out_flags = {invalid, overflow, underflow, inexact}
  localparam int unsigned FLAG_INV = 3;
  localparam int unsigned FLAG_OVF = 2;
  localparam int unsigned FLAG_UNF = 1;
  localparam int unsigned FLAG_INX = 0;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] mant;
    logic                is_zero;
    logic                is_inf;
    logic                is_nan;
    logic                is_snan;
  } fp_unpk_t;

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; an all-zero input returns IN_W.
module fpu_lzc #(
  parameter int unsigned IN_W = 27
) (
  input  logic [IN_W-1:0]            din,
  output logic [$clog2(IN_W+1)-1:0]  cnt
);

  localparam int unsigned CNT_W = $clog2(IN_W+1);

  // Scan upward so the highest set bit sets the final count
  always_comb begin
    cnt = CNT_W'(IN_W);
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (din[i]) cnt = CNT_W'(IN_W - 1 - i);
    end
  end

endmodule

// File: rtl/fadd_pipe.sv
// Three-stage floating-point add/subtract with valid/ready on both sides.
// S1 unpack/swap/align, S2 add and leading-zero count, S3 normalise/round/pack.
// The operand format follows fpu_pkg (FP_EXP_W / FP_MAN_W).
module fadd_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sub,
  input  logic [EXP_W+MAN_W:0]  in_op1,
  input  logic [EXP_W+MAN_W:0]  in_op2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MAN_W:0]  out_result,
  output logic [3:0]            out_flags
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned SW  = MAN_W + 4;          // hidden + mantissa + guard/round/sticky
  localparam int unsigned LZW = $clog2(SW + 1);
  localparam int unsigned EW  = EXP_W + 2;          // signed working exponent

  function automatic fp_unpk_t unpack(input logic [W-1:0] x);
    fp_unpk_t u;
    u.sign    = x[W-1];
    u.exp     = x[W-2:MAN_W];
    u.mant    = x[MAN_W-1:0];
    u.is_zero = (u.exp == '0);
    u.is_nan  = (u.exp == EXP_MAX) && (u.mant != '0);
    u.is_snan = u.is_nan && !u.mant[MAN_W-1];
    u.is_inf  = (u.exp == EXP_MAX) && (u.mant == '0);
    if (u.is_zero) u.mant = '0;                      // subnormals flush to signed zero
    return u;
  endfunction

  logic ld1, ld2, ld3, v1, v2, v3;

  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;

  // ---------------- S1: unpack, swap, align ----------------
  fp_unpk_t            ua, ub, big, sml;
  logic                a_big;
  logic [EXP_W-1:0]    ediff, shamt;
  logic [2*SW-1:0]     shifted;
  logic [SW-1:0]       mb_c, ms_c;
  logic                spec_c;
  logic [W-1:0]        sres_c;
  logic [3:0]          sflg_c;

  // Order operands by magnitude, align the smaller one and resolve specials
  always_comb begin
    ua      = unpack(in_op1);
    ub      = unpack(in_op2);
    ub.sign = ub.sign ^ in_sub;
    a_big   = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
    big     = a_big ? ua : ub;
    sml     = a_big ? ub : ua;
    ediff   = big.exp - sml.exp;
    shamt   = (ediff >= EXP_W'(MAN_W + 3)) ? EXP_W'(MAN_W + 3) : ediff;
    mb_c    = {!big.is_zero, big.mant, 3'b000};
    // Bits shifted out of the low half collapse into the sticky position
    shifted = {!sml.is_zero, sml.mant, 3'b000, {SW{1'b0}}} >> shamt;
    ms_c    = shifted[2*SW-1:SW] | {{(SW-1){1'b0}}, |shifted[SW-1:0]};
    spec_c  = 1'b1;
    sres_c  = CANON_NAN;
    sflg_c  = '0;
    if (ua.is_nan || ub.is_nan) begin
      sflg_c[FLAG_INV] = ua.is_snan || ub.is_snan;
    end else if (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)) begin
      sflg_c[FLAG_INV] = 1'b1;
    end else if (ua.is_inf) begin
      sres_c = {ua.sign, EXP_MAX, {MAN_W{1'b0}}};
    end else if (ub.is_inf) begin
      sres_c = {ub.sign, EXP_MAX, {MAN_W{1'b0}}};
    end else begin
      spec_c = 1'b0;
    end
  end

  logic              s1_sign, s1_sub, s1_spec;
  logic [EXP_W-1:0]  s1_exp;
  logic [SW-1:0]     s1_mb, s1_ms;
  logic [W-1:0]      s1_sres;
  logic [3:0]        s1_sflg;

  // S1 register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0; s1_spec <= 1'b0;
      s1_exp <= '0; s1_mb <= '0; s1_ms <= '0; s1_sres <= '0; s1_sflg <= '0;
    end else if (ld1) begin
      v1      <= in_valid;
      s1_sign <= big.sign;
      s1_sub  <= ua.sign ^ ub.sign;
      s1_spec <= spec_c;
      s1_exp  <= big.exp;
      s1_mb   <= mb_c;
      s1_ms   <= ms_c;
      s1_sres <= sres_c;
      s1_sflg <= sflg_c;
    end
  end

  // ---------------- S2: add/subtract, leading-zero count ----------------
  logic [SW:0]     sum_c;
  logic [LZW-1:0]  lz_c;

  // Magnitude ordering in S1 keeps the difference non-negative
  always_comb begin
    sum_c = s1_sub ? ({1'b0, s1_mb} - {1'b0, s1_ms}) : ({1'b0, s1_mb} + {1'b0, s1_ms});
  end

  fpu_lzc #(.IN_W(SW)) u_lzc (
    .din (sum_c[SW-1:0]),
    .cnt (lz_c)
  );

  logic              s2_sign, s2_sub, s2_spec;
  logic [EXP_W-1:0]  s2_exp;
  logic [SW:0]       s2_sum;
  logic [LZW-1:0]    s2_lz;
  logic [W-1:0]      s2_sres;
  logic [3:0]        s2_sflg;

  // S2 register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2 <= 1'b0; s2_sign <= 1'b0; s2_sub <= 1'b0; s2_spec <= 1'b0;
      s2_exp <= '0; s2_sum <= '0; s2_lz <= '0; s2_sres <= '0; s2_sflg <= '0;
    end else if (ld2) begin
      v2      <= v1;
      s2_sign <= s1_sign;
      s2_sub  <= s1_sub;
      s2_spec <= s1_spec;
      s2_exp  <= s1_exp;
      s2_sum  <= sum_c;
      s2_lz   <= lz_c;
      s2_sres <= s1_sres;
      s2_sflg <= s1_sflg;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [SW-1:0]         nm;
  logic signed [EW-1:0]  ne, ne_r;
  logic                  rup, inx;
  logic [MAN_W+1:0]      rm;
  logic [MAN_W-1:0]      frac;
  logic [W-1:0]          res_c;
  logic [3:0]            flg_c;

  // Normalise on the pre-round exponent, then RNE with carry into the exponent
  always_comb begin
    if (s2_sum[SW]) begin
      nm = s2_sum[SW:1] | {{(SW-1){1'b0}}, s2_sum[0]};
      ne = $signed(EW'(s2_exp) + EW'(1));
    end else begin
      nm = s2_sum[SW-1:0] << s2_lz;
      ne = $signed(EW'(s2_exp) - EW'(s2_lz));
    end
    inx = |nm[2:0];
    rup = nm[2] & (nm[1] | nm[0] | nm[3]);
    rm  = {1'b0, nm[SW-1:3]} + (MAN_W+2)'(rup);
    if (rm[MAN_W+1]) begin
      frac = rm[MAN_W:1];
      ne_r = ne + $signed(EW'(1));
    end else begin
      frac = rm[MAN_W-1:0];
      ne_r = ne;
    end
    res_c           = {s2_sign, ne_r[EXP_W-1:0], frac};
    flg_c           = '0;
    flg_c[FLAG_INX] = inx;
    if (s2_spec) begin
      res_c = s2_sres;
      flg_c = s2_sflg;
    end else if (s2_sum == '0) begin
      res_c = {s2_sign & !s2_sub, {(W-1){1'b0}}};
      flg_c = '0;
    end else if (ne < $signed(EW'(1))) begin
      res_c           = {s2_sign, {(W-1){1'b0}}};
      flg_c           = '0;
      flg_c[FLAG_UNF] = 1'b1;
      flg_c[FLAG_INX] = 1'b1;
    end else if (ne_r >= $signed(EW'(EXP_MAX))) begin
      res_c           = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
      flg_c           = '0;
      flg_c[FLAG_OVF] = 1'b1;
      flg_c[FLAG_INX] = 1'b1;
    end
  end

  // S3 is the output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v3         <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (ld3) begin
      v3         <= v2;
      out_result <= res_c;
      out_flags  <= flg_c;
    end
  end

endmodule
